// File: rtl/alu_cmd_queue_if.sv
// Command/result handshake bundle for alu_cmd_queue.
// master = command source + result consumer, slave = the queue itself.
interface alu_cmd_queue_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_opcode;
    logic [WIDTH-1:0] cmd_in1;
    logic [WIDTH-1:0] cmd_in2;
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_opcode;
    logic [WIDTH-1:0] res_high;
    logic [WIDTH-1:0] res_low;
    logic             res_flag;

    modport master (
        output cmd_valid, cmd_opcode, cmd_in1, cmd_in2, res_ready,
        input  cmd_ready, res_valid, res_opcode, res_high, res_low, res_flag
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_in1, cmd_in2, res_ready,
        output cmd_ready, res_valid, res_opcode, res_high, res_low, res_flag
    );
endinterface

// File: rtl/alu_cmd_queue.sv
// Command FIFO feeding one sequential add/sub/mul/div engine with a
// valid/ready result port; results return in acceptance order.
module alu_cmd_queue #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    alu_cmd_queue_if.slave bus,
    output logic [CW-1:0] count,
    output logic          busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [AW-1:0]    wptr, rptr;
    logic             full, push, pop;

    logic [1:0]       state;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic [WIDTH-1:0] hi, lo;
    logic             flag;
    logic [SW-1:0]    cnt;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_t;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    assign full  = (count == CW'(DEPTH));
    assign push  = bus.cmd_valid && !full;
    assign pop   = (state == IDLE) && (count != '0);
    assign head  = mem[rptr];

    assign bus.cmd_ready  = !full;
    assign bus.res_valid  = (state == DONE);
    assign bus.res_opcode = op_r;
    assign bus.res_high   = hi;
    assign bus.res_low    = lo;
    assign bus.res_flag   = flag;
    assign busy           = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= '{op: bus.cmd_opcode, a: bus.cmd_in1, b: bus.cmd_in2};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // mul: hi:lo is the shifting product, lo starts as the multiplier.
    // div: hi is the partial remainder, lo shifts dividend out / quotient in.
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_r} : '0);
        div_t    = {hi, lo[WIDTH-1]};
        div_ge   = (div_t >= {1'b0, b_r});
        div_diff = div_t - {1'b0, b_r};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            hi    <= '0;
            lo    <= '0;
            flag  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    op_r  <= head.op;
                    a_r   <= head.a;
                    b_r   <= head.b;
                    hi    <= '0;
                    lo    <= (head.op == OP_MUL) ? head.b : head.a;
                    flag  <= 1'b0;
                    cnt   <= ((head.op == OP_MUL) || (head.op == OP_DIV && head.b != '0))
                             ? SW'(WIDTH - 1) : '0;
                    state <= EXEC;
                end
                EXEC: begin
                    case (op_r)
                        OP_ADD: begin
                            {flag, lo} <= {1'b0, a_r} + {1'b0, b_r};
                            hi         <= '0;
                        end
                        OP_SUB: begin
                            lo   <= a_r - b_r;
                            flag <= (a_r < b_r);
                            hi   <= '0;
                        end
                        OP_MUL: begin
                            hi   <= mul_sum[WIDTH:1];
                            lo   <= {mul_sum[0], lo[WIDTH-1:1]};
                            flag <= (mul_sum[WIDTH:1] != '0);
                        end
                        default: begin
                            if (b_r == '0) begin
                                lo   <= '1;
                                hi   <= a_r;
                                flag <= 1'b1;
                            end else begin
                                hi   <= div_ge ? div_diff[WIDTH-1:0] : div_t[WIDTH-1:0];
                                lo   <= {lo[WIDTH-2:0], div_ge};
                                flag <= 1'b0;
                            end
                        end
                    endcase
                    cnt <= cnt - SW'(1);
                    if (cnt == '0) state <= DONE;
                end
                DONE: if (bus.res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// Bench for alu_cmd_queue: latency/value table, scoreboard-checked streams,
// backpressure capacity and mid-operation reset.
module tb_alu_cmd_queue;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CW-1:0] count;
    logic          busy;

    always #5 clk = ~clk;

    alu_cmd_queue_if #(.WIDTH(W)) bus ();

    alu_cmd_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .count (count),
        .busy  (busy)
    );

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         flag;
    } res_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         flag;
        int           lat;
    } vec_t;

    res_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_res  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t         r;
        logic [W:0]   s;
        logic [2*W-1:0] p;
        r = '0;
        r.op = op;
        case (op)
            2'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r.lo = s[W-1:0];
                r.flag = s[W];
            end
            2'd1: begin
                r.lo = a - b;
                r.flag = (a < b);
            end
            2'd2: begin
                p = (2*W)'(a) * (2*W)'(b);
                r.hi = p[2*W-1:W];
                r.lo = p[W-1:0];
                r.flag = (r.hi != 0);
            end
            default: begin
                if (b == 0) begin
                    r.lo = '1;
                    r.hi = a;
                    r.flag = 1'b1;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    // Monitor: sample between edges, score accepts and result handshakes.
    initial begin
        res_t e, cur, prev;
        logic prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {bus.res_opcode, bus.res_high, bus.res_low, bus.res_flag};
            if (!reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(bus.res_valid), 32'd1);
                    chk("hold_data", 32'(cur), 32'(prev));
                end
                if (bus.cmd_valid && bus.cmd_ready)
                    sb.push_back(model(bus.cmd_opcode, bus.cmd_in1, bus.cmd_in2));
                if (bus.res_valid && bus.res_ready) begin
                    n_res++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %0h expected none", cur);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_opcode", 32'(bus.res_opcode), 32'(e.op));
                        chk("sb_high", 32'(bus.res_high), 32'(e.hi));
                        chk("sb_low", 32'(bus.res_low), 32'(e.lo));
                        chk("sb_flag", 32'(bus.res_flag), 32'(e.flag));
                    end
                end
                prev_stall = bus.res_valid && !bus.res_ready;
                prev = cur;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic ok;
        ok = 1'b0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_in1    = a;
        bus.cmd_in2    = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.cmd_ready;
            tick();
        end
        bus.cmd_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got cmd_ready=0 expected 1");
        end
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (!busy && sb.size() == 0) ok = 1'b1;
            else tick();
        end
        chk("idle_reached", 32'(ok), 32'd1);
    endtask

    vec_t vecs[11];

    initial begin
        int lat, acc, n0;

        vecs[0]  = '{2'd0, 8'd200, 8'd100, 8'h00, 8'd44,  1'b1, 2};
        vecs[1]  = '{2'd1, 8'd5,   8'd7,   8'h00, 8'd254, 1'b1, 2};
        vecs[2]  = '{2'd2, 8'd255, 8'd255, 8'hFE, 8'h01,  1'b1, 9};
        vecs[3]  = '{2'd2, 8'd3,   8'd4,   8'h00, 8'd12,  1'b0, 9};
        vecs[4]  = '{2'd3, 8'd100, 8'd7,   8'd2,  8'd14,  1'b0, 9};
        vecs[5]  = '{2'd3, 8'd9,   8'd0,   8'd9,  8'hFF,  1'b1, 2};
        vecs[6]  = '{2'd0, 8'd10,  8'd20,  8'h00, 8'd30,  1'b0, 2};
        vecs[7]  = '{2'd1, 8'd7,   8'd7,   8'h00, 8'd0,   1'b0, 2};
        vecs[8]  = '{2'd3, 8'd7,   8'd9,   8'd7,  8'd0,   1'b0, 9};
        vecs[9]  = '{2'd2, 8'd16,  8'd16,  8'd1,  8'd0,   1'b1, 9};
        vecs[10] = '{2'd3, 8'd255, 8'd1,   8'd0,  8'd255, 1'b0, 9};

        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_in1    = '0;
        bus.cmd_in2    = '0;
        bus.res_ready  = 1'b1;

        tick();
        tick();
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_high", 32'(bus.res_high), 32'd0);
        chk("rst_res_low", 32'(bus.res_low), 32'd0);
        chk("rst_res_flag", 32'(bus.res_flag), 32'd0);
        chk("rst_res_opcode", 32'(bus.res_opcode), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        reset = 1'b1;
        tick();

        // Single commands into an idle, empty block: latency and values.
        foreach (vecs[v]) begin
            send(vecs[v].op, vecs[v].a, vecs[v].b);
            lat = 0;
            for (int k = 1; k <= 40 && lat == 0; k++) begin
                tick();
                if (bus.res_valid) lat = k;
            end
            chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
            chk($sformatf("v%0d_high", v), 32'(bus.res_high), 32'(vecs[v].hi));
            chk($sformatf("v%0d_low", v), 32'(bus.res_low), 32'(vecs[v].lo));
            chk($sformatf("v%0d_flag", v), 32'(bus.res_flag), 32'(vecs[v].flag));
            chk($sformatf("v%0d_opcode", v), 32'(bus.res_opcode), 32'(vecs[v].op));
            tick();
            wait_idle();
        end

        // Backpressure: capacity is DEPTH queued plus one held in DONE.
        bus.res_ready = 1'b0;
        acc = 0;
        n0 = n_res;
        for (int cyc = 0; cyc < 30; cyc++) begin
            bus.cmd_valid  = 1'b1;
            bus.cmd_opcode = 2'd0;
            bus.cmd_in1    = W'(acc + 1);
            bus.cmd_in2    = W'(acc + 1);
            @(negedge clk);
            if (bus.cmd_ready) acc++;
            tick();
        end
        bus.cmd_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd5);
        chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("bp_count", 32'(count), 32'd4);
        chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
        chk("bp_head_low", 32'(bus.res_low), 32'd2);
        chk("bp_busy", 32'(busy), 32'd1);
        bus.res_ready = 1'b1;
        wait_idle();
        chk("bp_results", 32'(n_res - n0), 32'd5);
        chk("bp_count_drained", 32'(count), 32'd0);
        chk("bp_busy_drop", 32'(busy), 32'd0);

        // Mixed back-to-back stream.
        n0 = n_res;
        send(2'd2, 8'd15, 8'd15);
        send(2'd0, 8'd1, 8'd2);
        send(2'd3, 8'd50, 8'd5);
        wait_idle();
        chk("mix_results", 32'(n_res - n0), 32'd3);

        // Reset in mid-EXEC of a mul with two commands queued.
        send(2'd2, 8'd3, 8'd3);
        send(2'd0, 8'd1, 8'd1);
        send(2'd0, 8'd2, 8'd2);
        tick();
        tick();
        chk("pre_rst_count", 32'(count), 32'd2);
        reset = 1'b0;
        #1;
        chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        sb.delete();
        tick();
        reset = 1'b1;
        n0 = n_res;
        send(2'd0, 8'd7, 8'd8);
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            tick();
            if (bus.res_valid) lat = k;
        end
        chk("post_rst_latency", 32'(lat), 32'd2);
        chk("post_rst_low", 32'(bus.res_low), 32'd15);
        wait_idle();
        repeat (20) tick();
        chk("post_rst_no_stale", 32'(n_res - n0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_cmd_queue.md
Name: alu_cmd_queue

Overview:
- Parametrised successor to the start/done sequential ALU controllers: add, sub, mul and div share one sequential execution engine.
- Commands enter through a DEPTH-entry command FIFO with a valid/ready handshake.
- Results leave through a valid/ready result port with backpressure, so back-to-back operations need no per-operation reset/start sequencing.
- Sits between the ALU command source and the result consumer in the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- DEPTH, 4, command FIFO entries (power of 2, >=2).
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridden).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_opcode  input  2  00 add, 01 sub, 10 mul, 11 div.
- cmd_in1  input  WIDTH  operand A (dividend for div).
- cmd_in2  input  WIDTH  operand B (divisor for div).
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- res_opcode  output  2  opcode of the returned result.
- res_high  output  WIDTH  upper result word.
- res_low  output  WIDTH  lower result word.
- res_flag  output  1  carry/borrow/overflow/div-by-zero.
- count  output  CW  FIFO occupancy, 0..DEPTH.
- busy  output  1  engine not IDLE or count!=0.

Behaviour:
- Reset (reset=0, async): FIFO emptied and all queued commands discarded; engine -> IDLE.
  - Outputs while in reset: res_valid=0, res_high=0, res_low=0, res_flag=0, res_opcode=0, count=0, busy=0, cmd_ready=1.
  - Reset mid-operation abandons the in-flight command with no partial result.
- Push: on an edge with cmd_valid && cmd_ready, write the command at the tail and increment count. No write when full, even if a pop occurs in the same cycle.
- Pop: on an edge where the engine is IDLE and count!=0, load the head into the operand registers, decrement count and enter EXEC.
  - Simultaneous push and pop leaves count unchanged.
  - No bypass: a command pushed at edge A is popped no earlier than edge A+1.
- Engine states: IDLE -> EXEC -> DONE -> IDLE.
  - EXEC length N: add/sub N=1; mul N=WIDTH (shift-add, one multiplier bit per cycle); div with in2!=0 N=WIDTH (restoring, one quotient bit per cycle); div with in2==0 N=1.
  - DONE is entered N edges after the pop. Outputs are registered, res_valid=1 in DONE.
  - DONE holds res_* stable until an edge with res_ready=1, then goes to IDLE. The next pop can happen at the following edge, so the minimum gap is one IDLE cycle.
  - Accept-to-res_valid latency into an idle, empty block is N+1 edges.
- Result rules (results are modulo 2^WIDTH unless stated):
  - add: res_low = A+B; res_high = 0; res_flag = carry out.
  - sub: res_low = A-B (two's-complement wrap); res_high = 0; res_flag = (A<B) borrow.
  - mul: {res_high,res_low} = A*B (2*WIDTH bits); res_flag = (res_high!=0).
  - div: res_low = quotient, res_high = remainder, res_flag = 0.
  - div by zero: res_low = all ones, res_high = A, res_flag = 1.
- res_opcode echoes the opcode of the command being returned.
- Ordering: results are returned strictly in command acceptance order.
- Capacity: with res_ready held low, at most DEPTH+1 commands are accepted (DEPTH queued plus one held in DONE).
- FIFO pointers wrap modulo DEPTH; full when count==DEPTH, empty when count==0.
- cmd_opcode, cmd_in1 and cmd_in2 are sampled only on an accepting edge.

Test Plan:
- All cases use WIDTH=8, DEPTH=4.
- Add: 200+100, accepted at edge A, res_ready=1 -> res_valid at A+2; res_low=44, res_high=0, res_flag=1, res_opcode=00. Sub 5-7 -> res_low=254, res_flag=1.
- Mul: 255*255 accepted at A -> res_valid at A+9; res_high=0xFE, res_low=0x01, res_flag=1. Mul 3*4 -> high=0, low=12, flag=0.
- Div: 100/7 -> res_low=14, res_high=2, flag=0, res_valid at A+9. Div 9/0 -> res_low=0xFF, res_high=9, flag=1, res_valid at A+2.
- Backpressure: res_ready=0, cmd_valid held with adds 1+1, 2+2, ..., 6+6 -> exactly 5 accepted; cmd_ready=0 with count=4. Then res_ready=1 -> results 2,4,6,8,10 in order, each held stable while stalled; count drains to 0, busy drops after last handshake.
- Mixed stream: mul 15*15, add 1+2, div 50/5 back-to-back with res_ready=1 -> results 225, 3, q=10 r=0 in order; res_opcode 10, 00, 11.
- Reset: reset=0 for one cycle in mid-EXEC of a mul with 2 commands queued -> res_valid=0, count=0, busy=0 immediately. After release, add 7+8 -> res_low=15 and no stale results appear.
